cordic_nco_mc: RTL and testbench

Multi-channel, time-multiplexed numerically controlled oscillator. It keeps one phase accumulator, frequency tuning word (FTW) and phase offset word (POW) per channel. Each cycle it issues one channel's phase into a shared, fully pipelined CORDIC rotator that produces saturated signed cos/sin samples. Each output sample carries a valid strobe and a channel tag. The block sits between the configuration register bus and the DAC/mixer datapath and replaces single-channel, angle-driven sin/cos generation.

---
 rtl/cordic_nco_mc.sv | 194 +++++++++++++++++++
 tb/tb_cordic_nco_mc.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_nco_mc.sv
// cordic_nco_mc: multi-channel, time-multiplexed NCO feeding a shared,
// fully pipelined CORDIC rotator. Each cycle with en=1 one channel's phase
// is issued. Samples come out as saturated signed cos/sin with a channel tag.
// Optional build macro: CORDIC_NCO_DITHER_EN adds LFSR phase dither ahead of
// the 20-bit angle truncation.
module cordic_nco_mc #(
    parameter int          CH_NUM      = 4,
    parameter int          PHASE_WIDTH = 32,
    parameter int          OUT_WIDTH   = 16,
    parameter int          OUT_REG_EN  = 1,
    parameter logic [15:0] K           = 16'h4DBA,
    localparam int         CW          = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   clr,
    input  logic                   cfg_we,
    input  logic                   cfg_sel,
    input  logic [CW-1:0]          cfg_addr,
    input  logic [PHASE_WIDTH-1:0] cfg_data,
    output logic                   out_valid,
    output logic [CW-1:0]          out_ch,
    output logic [OUT_WIDTH-1:0]   cos_o,
    output logic [OUT_WIDTH-1:0]   sin_o
);

    localparam int PW     = PHASE_WIDTH;
    localparam int AW     = 20;             // angle width: 2^20 = one turn
    localparam int ZW     = 21;             // residual-angle width (signed)
    localparam int XW     = OUT_WIDTH + 5;  // x/y width, 4 guard LSBs
    localparam int STAGES = OUT_WIDTH;

    // Gain-compensated start vector, left-aligned to the output width.
    localparam logic signed [XW-1:0] KX = {1'b0, K[15 -: OUT_WIDTH], 4'b0000};

    // atan(2^-k) in units of 2^-20 turn.
    localparam logic [ZW-1:0] ATAN [16] = '{
        21'h20000, 21'h12E40, 21'h09FB4, 21'h05111,
        21'h028B1, 21'h0145D, 21'h00A2F, 21'h00518,
        21'h0028C, 21'h00146, 21'h000A3, 21'h00051,
        21'h00029, 21'h00014, 21'h0000A, 21'h00005
    };

    // ---------------------------------------------------------------- state
    logic [PW-1:0]  acc [CH_NUM];
    logic [PW-1:0]  ftw [CH_NUM];
    logic [AW-1:0]  pow [CH_NUM];
    logic [CW-1:0]  cnt;
    logic           issue;
    logic           cfg_hit;
    logic [AW-1:0]  angle;

    assign issue   = en & ~clr;
    assign cfg_hit = cfg_we && (32'(cfg_addr) < CH_NUM);

    // Phase accumulators and channel counter; clear wins over issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) acc[i] <= '0;
            cnt <= '0;
        end else if (clr) begin
            for (int i = 0; i < CH_NUM; i++) acc[i] <= '0;
            cnt <= '0;
        end else if (en) begin
            acc[cnt] <= acc[cnt] + ftw[cnt];
            cnt      <= (cnt == CW'(CH_NUM - 1)) ? '0 : cnt + CW'(1);
        end
    end

    // Configuration registers; an issue at the same edge sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_NUM; i++) begin
                ftw[i] <= '0;
                pow[i] <= '0;
            end
        end else if (cfg_hit) begin
            if (cfg_sel) pow[cfg_addr] <= cfg_data[AW-1:0];
            else         ftw[cfg_addr] <= cfg_data;
        end
    end

`ifdef CORDIC_NCO_DITHER_EN
    localparam int DW = ((PW - AW) > 16) ? 16 : (PW - AW);
    logic [15:0] lfsr;

    // x^16+x^14+x^13+x^11+1 Fibonacci LFSR, one step per issued sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     lfsr <= 16'hACE1;
        else if (issue) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign angle = AW'((acc[cnt] + PW'(lfsr[DW-1:0])) >> (PW - AW)) + pow[cnt];
`else
    assign angle = acc[cnt][PW-1 -: AW] + pow[cnt];
`endif

    // ------------------------------------------------------ quadrant pre-map
    logic signed [XW-1:0] x_init;
    logic        [ZW-1:0] z_init;

    // Fold the angle into +/-90 degrees around a +K or -K start vector.
    always_comb begin
        x_init = KX;
        z_init = {1'b0, angle};
        unique case (angle[19:18])
            2'b00: begin x_init =  KX; z_init = {1'b0, angle};          end
            2'b01: begin x_init = -KX; z_init = {3'b111, angle[17:0]};  end
            2'b10: begin x_init = -KX; z_init = {3'b000, angle[17:0]};  end
            default: begin x_init = KX; z_init = {1'b1, angle};         end
        endcase
    end

    // --------------------------------------------------------- CORDIC pipe
    logic signed [XW-1:0] x_p  [STAGES+1];
    logic signed [XW-1:0] y_p  [STAGES+1];
    logic        [ZW-1:0] z_p  [STAGES+1];
    logic        [CW-1:0] ch_p [STAGES+1];
    logic [STAGES:0]      vld_pipe;

    // Stage 0 latches the pre-mapped vector; stage i rotates by atan(2^-(i-1)).
    // Data only moves with its valid bit, so idle stages hold their contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i <= STAGES; i++) begin
                x_p[i]  <= '0;
                y_p[i]  <= '0;
                z_p[i]  <= '0;
                ch_p[i] <= '0;
            end
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], issue};
            if (issue) begin
                x_p[0]  <= x_init;
                y_p[0]  <= '0;
                z_p[0]  <= z_init;
                ch_p[0] <= cnt;
            end
            for (int i = 1; i <= STAGES; i++) begin
                if (vld_pipe[i-1]) begin
                    ch_p[i] <= ch_p[i-1];
                    if (!z_p[i-1][ZW-1]) begin
                        x_p[i] <= x_p[i-1] - (y_p[i-1] >>> (i - 1));
                        y_p[i] <= y_p[i-1] + (x_p[i-1] >>> (i - 1));
                        z_p[i] <= z_p[i-1] - ATAN[i-1];
                    end else begin
                        x_p[i] <= x_p[i-1] + (y_p[i-1] >>> (i - 1));
                        y_p[i] <= y_p[i-1] - (x_p[i-1] >>> (i - 1));
                        z_p[i] <= z_p[i-1] + ATAN[i-1];
                    end
                end
            end
        end
    end

    // Symmetric saturation of the guard-stripped OUT_WIDTH+1 bit value.
    function automatic logic [OUT_WIDTH-1:0] sat(input logic [OUT_WIDTH:0] t);
        if (t[OUT_WIDTH] != t[OUT_WIDTH-1])
            sat = t[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-2){1'b0}}, 1'b1}
                               : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else
            sat = t[OUT_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------- output
    generate
        if (OUT_REG_EN != 0) begin : g_oreg
            // Registered outputs; data holds while no sample is valid.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_valid <= 1'b0;
                    out_ch    <= '0;
                    cos_o     <= '0;
                    sin_o     <= '0;
                end else begin
                    out_valid <= vld_pipe[STAGES];
                    if (vld_pipe[STAGES]) begin
                        out_ch <= ch_p[STAGES];
                        cos_o  <= sat(x_p[STAGES][XW-1:4]);
                        sin_o  <= sat(y_p[STAGES][XW-1:4]);
                    end
                end
            end
        end else begin : g_ocomb
            assign out_valid = vld_pipe[STAGES];
            assign out_ch    = ch_p[STAGES];
            assign cos_o     = sat(x_p[STAGES][XW-1:4]);
            assign sin_o     = sat(y_p[STAGES][XW-1:4]);
        end
    endgenerate

endmodule

// File: tb/tb_cordic_nco_mc.sv
// Scoreboard bench for cordic_nco_mc at default parameters (4 channels,
// 32-bit phase, 16-bit samples, registered output). Stimulus pushes the
// expected channel, angle and arrival cycle; the monitor pops on out_valid.
module tb_cordic_nco_mc;

    localparam int  CH  = 4;
    localparam int  LAT = 18;   // issue edge counts as the first of 18 edges
    localparam real PI  = 3.14159265358979;
    localparam real AMP = 32767.0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        cfg_we = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] cos_o;
    logic [15:0] sin_o;

    always #5 clk = ~clk;

    cordic_nco_mc #(
        .CH_NUM(4), .PHASE_WIDTH(32), .OUT_WIDTH(16), .OUT_REG_EN(1), .K(16'h4DBA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ch(out_ch), .cos_o(cos_o), .sin_o(sin_o)
    );

    typedef struct {
        int ch;
        int ang;
        int cyc;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] m_acc [CH];
    logic [31:0] m_ftw [CH];
    logic [19:0] m_pow [CH];
    int          m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic chk_near(input string name, input int act, input real req, input real tol);
        real d;
        d = $itor(act) - req;
        if (d < 0.0) d = -d;
        checks++;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0.1f +/- %0.1f", name, act, req, tol);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lim);
        checks++;
        if (act < lim) begin
            errors++;
            $display("FAIL %s: got %0d, expected >= %0d", name, act, lim);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d, expected <= %0d", name, act, lim);
        end
    endtask

    task automatic model_reset(input bit cfg_too);
        for (int i = 0; i < CH; i++) begin
            m_acc[i] = '0;
            if (cfg_too) begin
                m_ftw[i] = '0;
                m_pow[i] = '0;
            end
        end
        m_cnt = 0;
    endtask

    // Drive one cycle of inputs at a falling edge, advance the model to match
    // the coming rising edge, then wait for the next falling edge.
    task automatic step(input logic e, input logic c, input logic we, input logic sel,
                        input int addr, input logic [31:0] data);
        exp_t x;
        en = e; clr = c; cfg_we = we; cfg_sel = sel;
        cfg_addr = 2'(addr); cfg_data = data;
        if (rst_n) begin
            if (c) begin
                model_reset(1'b0);
            end else if (e) begin
                x.ch  = m_cnt;
                x.ang = int'(20'(m_acc[m_cnt][31:12] + m_pow[m_cnt]));
                x.cyc = cyc + LAT;
                q.push_back(x);
                m_acc[m_cnt] = m_acc[m_cnt] + m_ftw[m_cnt];
                m_cnt = (m_cnt + 1) % CH;
            end
            if (we && addr < CH) begin
                if (sel) m_pow[addr] = data[19:0];
                else     m_ftw[addr] = data;
            end
        end
        @(negedge clk);
    endtask

    // Monitor: compare every presented sample against the scoreboard head.
    always @(negedge clk) begin : mon
        exp_t e;
        int   c;
        int   s;
        real  ph;
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_valid: out_valid=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e  = q.pop_front();
                    c  = int'($signed(cos_o));
                    s  = int'($signed(sin_o));
                    ph = 2.0 * PI * real'(e.ang) / 1048576.0;
                    chk_int("out_ch", int'(out_ch), e.ch);
                    chk_int("out_cycle", cyc, e.cyc);
                    chk_near("cos_o", c, AMP * $cos(ph), 8.0);
                    chk_near("sin_o", s, AMP * $sin(ph), 8.0);
                    if (e.ang == 'h40000) begin
                        chk_ge("sin_at_90", s, 32760);
                        chk_le("abs_cos_at_90", (c < 0) ? -c : c, 4);
                    end
                    if (e.ang == 'h80000) chk_le("cos_at_180", c, -32760);
                end
            end else if (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_valid: ch%0d due at cycle %0d, out_valid=0 at cycle %0d",
                         e.ch, e.cyc, cyc);
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        chk_int(name, q.size(), 0);
    endtask

    initial begin
        model_reset(1'b1);

        // Reset held with en=1: everything quiet.
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_int("rst_out_valid", int'(out_valid), 0);
            chk_int("rst_out_ch", int'(out_ch), 0);
            chk_int("rst_cos_o", int'(cos_o), 0);
            chk_int("rst_sin_o", int'(sin_o), 0);
        end
        rst_n = 1'b1;
        en    = 1'b0;
        @(negedge clk);

        // ch0 fixed 90 deg, ch1 steps 45 deg, ch2 fixed 180 deg, ch3 arbitrary.
        step(0, 0, 1, 0, 0, 32'h0000_0000);
        step(0, 0, 1, 1, 0, 32'h0004_0000);
        step(0, 0, 1, 0, 1, 32'h2000_0000);
        step(0, 0, 1, 1, 1, 32'h0000_0000);
        step(0, 0, 1, 0, 2, 32'h0000_0000);
        step(0, 0, 1, 1, 2, 32'hFFF8_0000);   // only the low 20 bits land
        step(0, 0, 1, 0, 3, 32'h0C00_0000);
        step(0, 0, 1, 1, 3, 32'h0001_2345);

        // Continuous issue: 8 samples per channel, full 45-degree wheel on ch1.
        repeat (32) step(1, 0, 0, 0, 0, 0);

        // en gaps 1,0,0,1 must reappear on out_valid.
        repeat (3) begin
            step(1, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0, 0);
        end

        // clr together with en: no issue, next issue is ch0 from acc=0.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        repeat (6) step(1, 0, 0, 0, 0, 0);

        // FTW write to the channel issuing at that same edge.
        step(1, 0, 1, 0, m_cnt, 32'h4000_0000);
        repeat (10) step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, m_cnt, 32'h0002_0000);
        repeat (8) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        drain("drain_main");

        // Mid-pipeline reset: 10 samples in flight, first one at the output.
        repeat (10) step(1, 0, 0, 0, 0, 0);
        repeat (8) step(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        q.delete();
        model_reset(1'b1);
        #1;
        chk_int("async_rst_out_valid", int'(out_valid), 0);
        chk_int("async_rst_cos_o", int'(cos_o), 0);
        chk_int("async_rst_sin_o", int'(sin_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) step(0, 0, 0, 0, 0, 0);

        // Recovery: config was cleared, ch0 now at 45 deg.
        step(0, 0, 1, 1, 0, 32'h0002_0000);
        repeat (4) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
